// File: rtl/multiplexador_n_registrado.sv
// -----------------------------------------------------------------------------
// multiplexador_n_registrado
//   N-channel, W-bit multiplexer with a registered output slot and a
//   valid/ready handshake on every input channel and on the output.
//   Channel selection is either fixed (external seletor) or round-robin
//   (the next valid channel after the last one granted).
//
// Parameters
//   LARGURA  data width of each channel and of resultado
//   CANAIS   number of input channels (>= 2)
//   SEL_W    selector width, 2**SEL_W >= CANAIS
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   entradas            flattened channel data, channel c at [c*LARGURA +: LARGURA]
//   valido / pronto     per-channel handshake (accepted when both are 1)
//   modo                0 = fixed select, 1 = round-robin
//   seletor             channel index in fixed mode
//   resultado           registered output word
//   resultado_valido    resultado holds an unconsumed word
//   resultado_pronto    consumer takes resultado this cycle
//   canal_atual         channel the word in resultado came from
//   resultado_paridade  (only with MUX_PARIDADE_EN) XOR of the held word
//
// Optional feature: define MUX_PARIDADE_EN to add resultado_paridade.
// -----------------------------------------------------------------------------
module multiplexador_n_registrado #(
    parameter int LARGURA = 16,
    parameter int CANAIS  = 4,
    parameter int SEL_W   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CANAIS*LARGURA-1:0] entradas,
    input  logic [CANAIS-1:0]         valido,
    output logic [CANAIS-1:0]         pronto,
    input  logic                      modo,
    input  logic [SEL_W-1:0]          seletor,
    output logic [LARGURA-1:0]        resultado,
    output logic                      resultado_valido,
    input  logic                      resultado_pronto,
    output logic [SEL_W-1:0]          canal_atual
`ifdef MUX_PARIDADE_EN
    ,
    output logic                      resultado_paridade
`endif
);

    logic [SEL_W-1:0]          ptr;       // last channel granted in round-robin
    logic                      livre;     // output slot can take a word this cycle
    logic                      tem_grant;
    logic [SEL_W-1:0]          g;
    logic [CANAIS-1:0]         rot;
    logic [CANAIS*LARGURA-1:0] desloc;
    logic [LARGURA-1:0]        dado_sel;
    int                        idx;

    // Grant selection. Shifting the vectors instead of indexing keeps the
    // index width independent of SEL_W vs. clog2(CANAIS).
    always_comb begin
        livre     = !resultado_valido || resultado_pronto;
        tem_grant = 1'b0;
        g         = '0;
        rot       = '0;
        idx       = 0;
        if (!modo) begin
            // Out-of-range selector simply yields no grant.
            if ({1'b0, seletor} < (SEL_W+1)'(CANAIS)) begin
                rot = valido >> seletor;
                if (rot[0]) begin
                    tem_grant = 1'b1;
                    g         = seletor;
                end
            end
        end else begin
            // Scan ptr+1, ptr+2, ... with wrap; the first valid channel wins.
            for (int i = 1; i <= CANAIS; i++) begin
                idx = (int'(ptr) + i) % CANAIS;
                rot = valido >> idx;
                if (!tem_grant && rot[0]) begin
                    tem_grant = 1'b1;
                    g         = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        desloc   = entradas >> (int'(g) * LARGURA);
        dado_sel = desloc[LARGURA-1:0];
    end

    // Only the granted channel sees ready, and only when the slot is free.
    always_comb begin
        pronto = '0;
        if (tem_grant && livre && !reset)
            pronto = CANAIS'(1) << g;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resultado        <= '0;
            resultado_valido <= 1'b0;
            canal_atual      <= '0;
            ptr              <= SEL_W'(CANAIS - 1);  // channel 0 wins first
`ifdef MUX_PARIDADE_EN
            resultado_paridade <= 1'b0;
`endif
        end else if (tem_grant && livre) begin
            resultado        <= dado_sel;
            resultado_valido <= 1'b1;
            canal_atual      <= g;
            if (modo)
                ptr <= g;
`ifdef MUX_PARIDADE_EN
            resultado_paridade <= ^dado_sel;
`endif
        end else if (resultado_pronto) begin
            // Consumer took the word and nothing replaces it: drain only.
            resultado_valido <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiplexador_n_registrado.sv
`timescale 1ns/100ps
module tb_multiplexador_n_registrado;

    localparam int LARGURA = 16;
    localparam int CANAIS  = 4;
    localparam int SEL_W   = 3;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic [CANAIS*LARGURA-1:0] entradas = '0;
    logic [CANAIS-1:0]         valido = '0;
    logic [CANAIS-1:0]         pronto;
    logic                      modo = 1'b0;
    logic [SEL_W-1:0]          seletor = '0;
    logic [LARGURA-1:0]        resultado;
    logic                      resultado_valido;
    logic                      resultado_pronto = 1'b0;
    logic [SEL_W-1:0]          canal_atual;
`ifdef MUX_PARIDADE_EN
    logic                      resultado_paridade;
`endif

    int errors = 0;
    int checks = 0;

    multiplexador_n_registrado #(.LARGURA(LARGURA), .CANAIS(CANAIS), .SEL_W(SEL_W)) dut (
        .clock(clock), .reset(reset), .entradas(entradas), .valido(valido),
        .pronto(pronto), .modo(modo), .seletor(seletor), .resultado(resultado),
        .resultado_valido(resultado_valido), .resultado_pronto(resultado_pronto),
        .canal_atual(canal_atual)
`ifdef MUX_PARIDADE_EN
        , .resultado_paridade(resultado_paridade)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [LARGURA-1:0] m_res;
    logic               m_val;
    int                 m_canal;
    int                 m_ptr;
    logic               m_par;

    // Which channel the rules grant now; -1 when none.
    function automatic int grant_of(input logic md, input int sel, input logic [CANAIS-1:0] v,
                                    input int last);
        if (!md) return (sel < CANAIS && v[sel]) ? sel : -1;
        for (int k = 1; k <= CANAIS; k++)
            if (v[(last + k) % CANAIS]) return (last + k) % CANAIS;
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin
        int gg;
        if (reset) begin
            m_res <= '0; m_val <= 1'b0; m_canal <= 0; m_ptr <= CANAIS - 1; m_par <= 1'b0;
        end else begin
            gg = grant_of(modo, int'(seletor), valido, m_ptr);
            if (gg >= 0 && (!m_val || resultado_pronto)) begin
                m_res   <= entradas[gg*LARGURA +: LARGURA];
                m_par   <= ^entradas[gg*LARGURA +: LARGURA];
                m_val   <= 1'b1;
                m_canal <= gg;
                if (modo) m_ptr <= gg;
            end else if (resultado_pronto) begin
                m_val <= 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clock) begin
        int gg;
        logic [CANAIS-1:0] exp_pronto;
        gg = grant_of(modo, int'(seletor), valido, m_ptr);
        exp_pronto = '0;
        if (!reset && gg >= 0 && (!m_val || resultado_pronto)) exp_pronto[gg] = 1'b1;
        chk("cyc_pronto", 32'(pronto), 32'(exp_pronto));
        chk("cyc_valido", 32'(resultado_valido), 32'(m_val));
        if (m_val) begin
            chk("cyc_resultado", 32'(resultado), 32'(m_res));
            chk("cyc_canal", 32'(canal_atual), 32'(m_canal));
`ifdef MUX_PARIDADE_EN
            chk("cyc_paridade", 32'(resultado_paridade), 32'(m_par));
`endif
        end
    end

    task automatic set_ch(input int c, input logic [LARGURA-1:0] d);
        entradas[c*LARGURA +: LARGURA] = d;
    endtask

    task automatic edge_wait;
        @(posedge clock); #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_resultado", 32'(resultado), 32'h0);
        chk("rst_valido", 32'(resultado_valido), 32'h0);
        chk("rst_canal", 32'(canal_atual), 32'h0);
        valido = 4'b1111;
        #1 chk("rst_pronto", 32'(pronto), 32'h0);
        valido = '0;
        edge_wait; edge_wait;
        reset = 1'b0;

        // Fixed select of channel 2.
        modo = 1'b0; seletor = 3'd2; set_ch(2, 16'h00A5); valido = 4'b0100; resultado_pronto = 1'b1;
        #1 chk("fix_pronto", 32'(pronto), 32'h4);
        edge_wait;
        chk("fix_resultado", 32'(resultado), 32'h00A5);
        chk("fix_canal", 32'(canal_atual), 32'd2);
        chk("fix_valido", 32'(resultado_valido), 32'd1);

        // Round-robin fairness: ptr untouched by fixed mode, so starts at 0.
        modo = 1'b1; valido = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            edge_wait;
            chk("rr_canal", 32'(canal_atual), 32'(i % 4));
        end

        // Backpressure.
        modo = 1'b0; seletor = 3'd1; set_ch(1, 16'h1234); valido = 4'b0010;
        edge_wait;
        chk("bp_load", 32'(resultado), 32'h1234);
        resultado_pronto = 1'b0; valido = 4'b1111; set_ch(2, 16'hBEEF); set_ch(0, 16'h5555);
        for (int i = 0; i < 3; i++) begin
            seletor = (i % 2 == 0) ? 3'd0 : 3'd2;
            #1 chk("bp_pronto", 32'(pronto), 32'h0);
            edge_wait;
            chk("bp_hold", 32'(resultado), 32'h1234);
            chk("bp_canal", 32'(canal_atual), 32'd1);
        end
        resultado_pronto = 1'b1; seletor = 3'd2;
        #1 chk("bp_release_pronto", 32'(pronto), 32'h4);
        edge_wait;
        chk("bp_next", 32'(resultado), 32'hBEEF);

        // Drain with out-of-range selector.
        seletor = 3'd5;
        #1 chk("oor_pronto", 32'(pronto), 32'h0);
        edge_wait;
        chk("oor_valido", 32'(resultado_valido), 32'd0);
        chk("oor_hold", 32'(resultado), 32'hBEEF);

        // Async reset while holding a word, then round-robin restarts at 0.
        seletor = 3'd3; set_ch(3, 16'hCAFE);
        edge_wait;
        resultado_pronto = 1'b0; valido = '0;
        @(posedge clock); #2.5 reset = 1'b1;
        #0.5;
        chk("arst_resultado", 32'(resultado), 32'h0);
        chk("arst_valido", 32'(resultado_valido), 32'h0);
        #0.5 reset = 1'b0;
        modo = 1'b1; valido = 4'b1111; resultado_pronto = 1'b1;
        edge_wait;
        chk("arst_rr0", 32'(canal_atual), 32'd0);

`ifdef MUX_PARIDADE_EN
        modo = 1'b0; seletor = 3'd0; set_ch(0, 16'h0007); valido = 4'b0001;
        edge_wait;
        chk("par_7", 32'(resultado_paridade), 32'd1);
        set_ch(0, 16'h0003);
        edge_wait;
        chk("par_3", 32'(resultado_paridade), 32'd0);
`endif

        // Randomized traffic, checked by the per-cycle compare process.
        for (int i = 0; i < 400; i++) begin
            entradas         = {$urandom, $urandom};
            valido           = 4'($urandom);
            seletor          = 3'($urandom_range(0, 7));
            modo             = 1'($urandom_range(0, 3) == 0 ? 0 : 1) ^ 1'(i / 100 % 2);
            resultado_pronto = 1'($urandom_range(0, 3) != 0);
            edge_wait;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
